bp_fetch_unit: RTL and testbench

Parametrised next-generation fetch stage for the 5-stage MIPS pipeline. It owns the PC register, PC+4 adder and a direct-mapped branch target buffer (BTB) with saturating taken counters. It predicts next PC in the F stage and accepts branch/jump resolution from decode, issuing a redirect plus FD flush on mispredict. Also keeps wrap-around performance counters.

---
 rtl/bp_fetch_unit_pkg.sv | 31 +++
 rtl/bp_fetch_unit_counter.sv | 25 ++
 rtl/bp_fetch_unit.sv | 120 ++++++++++++
 tb/tb_bp_fetch_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bp_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: parameter defaults, BTB geometry helpers
// and the counter operation encoding.
package bp_fetch_unit_pkg;

  localparam int unsigned DefXlen       = 32;
  localparam int unsigned DefBtbEntries = 16;
  localparam int unsigned DefCtrBits    = 2;
  localparam logic [31:0] DefResetPc    = 32'h0000_0000;

  typedef enum logic [1:0] {
    CtrHold,
    CtrInc,
    CtrDec,
    CtrInit
  } ctr_op_e;

  function automatic int unsigned idx_bits(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag covers everything above the index; the two byte-offset bits are dropped.
  function automatic int unsigned tag_bits(input int unsigned xlen, input int unsigned entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Weakly-taken initial value: only the MSB set.
  function automatic int unsigned weak_taken(input int unsigned ctr_bits);
    return 32'd1 << (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/bp_fetch_unit_counter.sv
// Saturating taken counter next-state logic for one BTB entry.
module btb_sat_counter
  import bp_fetch_unit_pkg::*;
#(
  parameter int unsigned CTR_BITS = DefCtrBits
) (
  input  logic [CTR_BITS-1:0] cnt_i,
  input  ctr_op_e             op_i,
  output logic [CTR_BITS-1:0] cnt_o
);

  localparam logic [CTR_BITS-1:0] WeakTaken = CTR_BITS'(weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CtrMax    = '1;

  always_comb begin
    cnt_o = cnt_i;
    unique case (op_i)
      CtrHold: cnt_o = cnt_i;
      CtrInc:  if (cnt_i != CtrMax) cnt_o = cnt_i + CTR_BITS'(1);
      CtrDec:  if (cnt_i != '0) cnt_o = cnt_i - CTR_BITS'(1);
      CtrInit: cnt_o = WeakTaken;
    endcase
  end

endmodule

// File: rtl/bp_fetch_unit.sv
// Fetch stage: PC register, PC+4, direct-mapped BTB with saturating counters,
// mispredict redirect/flush and wrap-around performance counters.
module bp_fetch_unit
  import bp_fetch_unit_pkg::*;
#(
  parameter int unsigned    XLEN        = DefXlen,
  parameter int unsigned    BTB_ENTRIES = DefBtbEntries,
  parameter int unsigned    CTR_BITS    = DefCtrBits,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DefResetPc)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  output logic [XLEN-1:0] pcf,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            res_valid_d,
  input  logic [XLEN-1:0] res_pc_d,
  input  logic            res_pred_taken_d,
  input  logic [XLEN-1:0] res_pred_target_d,
  input  logic            res_taken_d,
  input  logic [XLEN-1:0] res_target_d,
  output logic            flush_fd,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned IdxW = idx_bits(BTB_ENTRIES);
  localparam int unsigned TagW = tag_bits(XLEN, BTB_ENTRIES);

  typedef struct packed {
    logic                valid;
    logic [TagW-1:0]     tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } btb_entry_t;

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     branch_q, mispred_q;

  logic [IdxW-1:0]     f_idx, r_idx;
  logic                f_hit, r_hit;
  btb_entry_t          r_entry, r_entry_d;
  logic                btb_we;
  logic                mispredict;
  ctr_op_e             ctr_op;
  logic [CTR_BITS-1:0] ctr_next;

  assign pcf              = pc_q;
  assign pc_plus4_f       = pc_q + XLEN'(4);
  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

  // Lookup reads the registered array, so a same-cycle update is seen next cycle.
  assign f_idx         = pc_q[IdxW+1:2];
  assign f_hit         = btb_q[f_idx].valid && (btb_q[f_idx].tag == pc_q[XLEN-1:IdxW+2]);
  assign pred_taken_f  = f_hit && btb_q[f_idx].ctr[CTR_BITS-1];
  assign pred_target_f = pred_taken_f ? btb_q[f_idx].target : pc_plus4_f;

  assign r_idx   = res_pc_d[IdxW+1:2];
  assign r_entry = btb_q[r_idx];
  assign r_hit   = r_entry.valid && (r_entry.tag == res_pc_d[XLEN-1:IdxW+2]);

  assign mispredict = res_valid_d && ((res_pred_taken_d != res_taken_d) ||
                                      (res_taken_d && (res_pred_target_d != res_target_d)));
  assign flush_fd   = mispredict && !reset;

  // Not-taken misses leave the BTB alone; everything else writes the entry.
  assign btb_we = res_valid_d && (res_taken_d || r_hit);

  always_comb begin
    ctr_op = CtrHold;
    if (res_valid_d) begin
      if (res_taken_d) ctr_op = r_hit ? CtrInc : CtrInit;
      else if (r_hit)  ctr_op = CtrDec;
    end
  end

  btb_sat_counter #(
    .CTR_BITS(CTR_BITS)
  ) u_ctr (
    .cnt_i(r_entry.ctr),
    .op_i (ctr_op),
    .cnt_o(ctr_next)
  );

  always_comb begin
    r_entry_d     = r_entry;
    r_entry_d.ctr = ctr_next;
    if (res_taken_d) begin
      r_entry_d.valid  = 1'b1;
      r_entry_d.tag    = res_pc_d[XLEN-1:IdxW+2];
      r_entry_d.target = res_target_d;
    end
  end

  always_comb begin
    if (mispredict)   pc_d = res_taken_d ? res_target_d : res_pc_d + XLEN'(4);
    else if (stall_f) pc_d = pc_q;
    else              pc_d = pred_target_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      branch_q  <= '0;
      mispred_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (res_valid_d) branch_q <= branch_q + 32'd1;
      if (mispredict)  mispred_q <= mispred_q + 32'd1;
      if (btb_we)      btb_q[r_idx] <= r_entry_d;
    end
  end

endmodule

// File: tb/tb_bp_fetch_unit.sv
// Scoreboard bench for bp_fetch_unit: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_bp_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic [31:0] pcf, pc_plus4_f, pred_target_f;
  logic        pred_taken_f;
  logic        res_valid_d, res_pred_taken_d, res_taken_d;
  logic [31:0] res_pc_d, res_pred_target_d, res_target_d;
  logic        flush_fd;
  logic [31:0] branch_count, mispredict_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  bp_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall_f          (stall_f),
    .pcf              (pcf),
    .pc_plus4_f       (pc_plus4_f),
    .pred_taken_f     (pred_taken_f),
    .pred_target_f    (pred_target_f),
    .res_valid_d      (res_valid_d),
    .res_pc_d         (res_pc_d),
    .res_pred_taken_d (res_pred_taken_d),
    .res_pred_target_d(res_pred_target_d),
    .res_taken_d      (res_taken_d),
    .res_target_d     (res_target_d),
    .flush_fd         (flush_fd),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", nm, fld, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.name, "pcf", pcf, e.pc);
      chk(e.name, "pc_plus4_f", pc_plus4_f, e.pc + 32'd4);
      chk(e.name, "pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e.pt});
      chk(e.name, "pred_target_f", pred_target_f, e.ptgt);
      chk(e.name, "flush_fd", {31'd0, flush_fd}, {31'd0, e.fl});
      chk(e.name, "branch_count", branch_count, e.bc);
      chk(e.name, "mispredict_count", mispredict_count, e.mc);
    end
  end

  // Drive one cycle of inputs, queue the outputs expected during that cycle.
  task automatic step(input string nm, input logic rst, input logic stall, input logic rv,
                      input logic [31:0] rpc, input logic rpt, input logic [31:0] rptgt,
                      input logic rt, input logic [31:0] rtgt,
                      input logic [31:0] epc, input logic ept, input logic [31:0] eptgt,
                      input logic efl, input logic [31:0] ebc, input logic [31:0] emc);
    exp_t e;
    reset = rst; stall_f = stall; res_valid_d = rv; res_pc_d = rpc;
    res_pred_taken_d = rpt; res_pred_target_d = rptgt; res_taken_d = rt; res_target_d = rtgt;
    e.name = nm; e.pc = epc; e.pt = ept; e.ptgt = eptgt; e.fl = efl; e.bc = ebc; e.mc = emc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_f = 1'b0; res_valid_d = 1'b0; res_pc_d = '0;
    res_pred_taken_d = 1'b0; res_pred_target_d = '0; res_taken_d = 1'b0; res_target_d = '0;
    repeat (2) @(posedge clk);
    #1;
    //   name         rst stl rv  res_pc        rpt rptgt         rt  rtgt          pcf           pt  ptgt          fl  bc     mc
    step("rst0",      0,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h0,        0,  32'h4,        0,  32'd0, 32'd0);
    step("free4",     0,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h4,        0,  32'h8,        0,  32'd0, 32'd0);
    step("free8",     0,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h8,        0,  32'hC,        0,  32'd0, 32'd0);
    step("misp_tk",   0,  0,  1,  32'h10,       0,  32'h14,       1,  32'h40,       32'hC,        0,  32'h10,       1,  32'd0, 32'd0);
    step("redir40",   0,  0,  1,  32'hC,        1,  32'h40,       0,  32'h0,        32'h40,       0,  32'h44,       1,  32'd1, 32'd1);
    step("hit10_rbw", 0,  0,  1,  32'h10,       1,  32'h40,       0,  32'h0,        32'h10,       1,  32'h40,       1,  32'd2, 32'd2);
    step("dec1",      0,  0,  1,  32'h10,       0,  32'h14,       0,  32'h0,        32'h14,       0,  32'h18,       0,  32'd3, 32'd3);
    step("redir_a",   0,  0,  1,  32'hC,        1,  32'h40,       0,  32'h0,        32'h18,       0,  32'h1C,       1,  32'd4, 32'd3);
    step("nt_pred",   0,  0,  1,  32'h10,       0,  32'h14,       0,  32'h0,        32'h10,       0,  32'h14,       0,  32'd5, 32'd4);
    step("inc1",      0,  0,  1,  32'h10,       1,  32'h40,       1,  32'h40,       32'h14,       0,  32'h18,       0,  32'd6, 32'd4);
    step("inc2",      0,  0,  1,  32'h10,       1,  32'h40,       1,  32'h40,       32'h18,       0,  32'h1C,       0,  32'd7, 32'd4);
    step("inc3",      0,  0,  1,  32'h10,       1,  32'h40,       1,  32'h40,       32'h1C,       0,  32'h20,       0,  32'd8, 32'd4);
    step("inc_sat",   0,  0,  1,  32'h10,       1,  32'h40,       1,  32'h40,       32'h20,       0,  32'h24,       0,  32'd9, 32'd4);
    step("redir_b",   0,  0,  1,  32'hC,        1,  32'h40,       0,  32'h0,        32'h24,       0,  32'h28,       1,  32'd10, 32'd4);
    step("sat3_hit",  0,  0,  1,  32'h10,       1,  32'h40,       0,  32'h0,        32'h10,       1,  32'h40,       1,  32'd11, 32'd5);
    step("redir_c",   0,  0,  1,  32'hC,        1,  32'h40,       0,  32'h0,        32'h14,       0,  32'h18,       1,  32'd12, 32'd6);
    step("stall_misp",0,  1,  1,  32'h100,      0,  32'h104,      1,  32'h200,      32'h10,       1,  32'h40,       1,  32'd13, 32'd7);
    step("stall1",    0,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h200,      0,  32'h204,      0,  32'd14, 32'd8);
    step("stall2",    0,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h200,      0,  32'h204,      0,  32'd14, 32'd8);
    step("stall3",    0,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h200,      0,  32'h204,      0,  32'd14, 32'd8);
    step("unstall",   0,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h200,      0,  32'h204,      0,  32'd14, 32'd8);
    step("alias50",   0,  0,  1,  32'h50,       0,  32'h54,       1,  32'h80,       32'h204,      0,  32'h208,      1,  32'd14, 32'd8);
    step("redir_d",   0,  0,  1,  32'hC,        1,  32'h40,       0,  32'h0,        32'h80,       0,  32'h84,       1,  32'd15, 32'd9);
    step("alias_miss",0,  0,  1,  32'h4C,       1,  32'h40,       0,  32'h0,        32'h10,       0,  32'h14,       1,  32'd16, 32'd10);
    step("rst_mid",   1,  0,  1,  32'h50,       1,  32'h80,       1,  32'h300,      32'h50,       1,  32'h80,       0,  32'd17, 32'd11);
    step("post_rst",  0,  0,  1,  32'h4C,       1,  32'h40,       0,  32'h0,        32'h0,        0,  32'h4,        1,  32'd0, 32'd0);
    step("inval50",   0,  0,  1,  32'hFFFF_FFF8, 1, 32'h40,       0,  32'h0,        32'h50,       0,  32'h54,       1,  32'd1, 32'd1);
    step("wrap_pc",   0,  0,  1,  32'hFFFF_FFFC, 1, 32'h40,       0,  32'h0,        32'hFFFF_FFFC, 0, 32'h0,        1,  32'd2, 32'd2);
    step("wrap_res",  0,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        32'h0,        0,  32'h4,        0,  32'd3, 32'd3);
    // Bounded drain of any expectation the monitor has not consumed yet.
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
    chk("drain", "queue_left", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
